// File: rtl/alu_sequencer.sv
// Issue/writeback controller: decodes instructions, drives the ALU, writes results back.
// Optional ALU_SEQ_ZERO_REG_EN: reg[0] reads as zero and ignores writes.
module alu_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  logic [15:0]  instr,
    output logic         instr_ready,
    output logic [4:0]   alu_ctrl,
    output logic [N-1:0] src_A,
    output logic [N-1:0] src_B,
    input  logic [N-1:0] alu_result,
    output logic         busy,
    output logic         done,
    output logic         illegal,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    localparam logic [4:0] OP_LDI = 5'd17;

    state_t       state_q;
    logic [15:0]  instr_q;
    logic [N-1:0] res_q;
    logic [4:0]   alu_ctrl_q;
    logic [N-1:0] src_a_q;
    logic [N-1:0] src_b_q;
    logic         illegal_q;
    logic [N-1:0] rf_q [8];

    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       op_alu;
    logic       wr_en;

    assign op = instr_q[15:11];
    assign rd = instr_q[10:8];
    assign ra = instr_q[7:5];
    assign rb = instr_q[4:2];

    function automatic logic [N-1:0] rf_read(input logic [2:0] idx);
`ifdef ALU_SEQ_ZERO_REG_EN
        if (idx == 3'd0) return '0;
`endif
        return rf_q[idx];
    endfunction

    always_comb begin
        op_alu = 1'b0;
        case (op)
            5'd1, 5'd2, 5'd3, 5'd4,
            5'd9, 5'd10, 5'd11, 5'd12: op_alu = 1'b1;
            default:                   op_alu = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_ZERO_REG_EN
    assign wr_en = (rd != 3'd0);
`else
    assign wr_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            res_q      <= '0;
            alu_ctrl_q <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    if (op_alu) begin
                        alu_ctrl_q <= op;
                        src_a_q    <= rf_read(ra);
                        src_b_q    <= rf_read(rb);
                        state_q    <= EXEC;
                    end else if (op == OP_LDI) begin
                        res_q   <= {{(N-8){1'b0}}, instr_q[7:0]};
                        state_q <= WB;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                EXEC: begin
                    res_q   <= alu_result;
                    state_q <= WB;
                end
                WB: begin
                    if (wr_en) begin
                        rf_q[rd] <= res_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == WB);
    assign illegal     = illegal_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign src_A       = src_a_q;
    assign src_B       = src_b_q;
    assign dbg_data    = rf_read(dbg_addr);

endmodule
